// File: rtl/mesi_pkg.sv
// Shared MESI types: line states, bus operations and request payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mesi_pkg;

  localparam int NUM_CORES  = 2;
  localparam int LINE_BYTES = 16;
  localparam int MEM_BYTES  = 4096;
  localparam int MEM_ADDR_W = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    MODIFIED  = 2'b00,
    EXCLUSIVE = 2'b01,
    SHARED    = 2'b10,
    INVALID   = 2'b11
  } mesi_state_t;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_WB   = 2'b11
  } bus_op_t;

  typedef struct packed {
    bus_op_t                op;
    logic [MEM_ADDR_W-1:0]  addr;
  } bus_req_t;

  // Arbiter sequencing: pick a slot, offer it, wait for completion.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between full request slots.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arbiter2
  import mesi_pkg::*;
(
  input  logic [NUM_CORES-1:0] slot_full,
  input  logic                 rr_last,
  output logic                 grant_valid,
  output logic                 grant_id
);

  // A lone full slot wins outright; a tie goes to the core not served last.
  always_comb begin
    grant_valid = |slot_full;
    grant_id    = 1'b0;
    if (&slot_full) begin
      grant_id = ~rr_last;
    end else begin
      grant_id = slot_full[1];
    end
  end

endmodule

// File: rtl/coherence_request_arbiter.sv
// Serializes per-core coherence requests onto the controller bus, one in flight.
// Latency: slot load at edge N, bus_valid from edge N+1; min IDLE->IDLE turnaround 3 cycles.
// Backpressure: req_ready low while a core's slot is full; offer held until bus_ready; watchdog aborts a hung controller.
module coherence_request_arbiter
  import mesi_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [3:0]            req_op,
  input  logic [2*ADDR_W-1:0]   req_addr,
  output logic [1:0]            req_ready,
  output logic                  bus_valid,
  output logic                  bus_core,
  output logic [1:0]            bus_op,
  output logic [ADDR_W-1:0]     bus_addr,
  input  logic                  bus_ready,
  input  logic                  bus_done,
  output logic [1:0]            resp_done,
  output logic                  timeout_err
);

  localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_BYTES - 1);

  typedef struct packed {
    bus_op_t              op;
    logic [ADDR_W-1:0]    addr;
  } slot_t;

  slot_t [NUM_CORES-1:0] slot_q;
  logic  [NUM_CORES-1:0] slot_full;
  arb_state_t            state, state_nxt;
  logic                  rr_last;
  logic [CNT_W-1:0]      wd_cnt;
  logic                  grant_vld, grant_id;
  logic                  do_grant, do_finish, do_timeout;

  rr_arbiter2 u_rr (
    .slot_full   (slot_full),
    .rr_last     (rr_last),
    .grant_valid (grant_vld),
    .grant_id    (grant_id)
  );

  // Ready is the registered slot-empty flag, so a freed slot reopens only after the clearing edge.
  assign req_ready = ~slot_full;
  assign bus_valid = (state == ST_ISSUE);

  // Next-state and one-cycle control strobes; a done on the limit cycle wins over the watchdog.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_finish  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          do_grant  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus_ready) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus_done) begin
          do_finish = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wd_cnt == CNT_LIMIT) begin
          do_finish  = 1'b1;
          do_timeout = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Per-core slots: load on handshake, release when the granted transaction finishes or aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_full <= '0;
      slot_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (req_valid[i] && !slot_full[i]) begin
          slot_full[i]   <= 1'b1;
          slot_q[i].op   <= bus_op_t'(req_op[2*i +: 2]);
          slot_q[i].addr <= req_addr[ADDR_W*i +: ADDR_W];
        end else if (do_finish && (int'(bus_core) == i)) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  // Latch the granted request onto the bus and emit the completion/abort pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_core    <= 1'b0;
      bus_op      <= 2'b00;
      bus_addr    <= '0;
      resp_done   <= 2'b00;
      timeout_err <= 1'b0;
      rr_last     <= 1'b1;
    end else begin
      resp_done   <= 2'b00;
      timeout_err <= 1'b0;
      if (do_grant) begin
        bus_core <= grant_id;
        bus_op   <= slot_q[grant_id].op;
        bus_addr <= slot_q[grant_id].addr & LINE_MASK;
      end
      if (do_finish) begin
        resp_done   <= 2'b01 << bus_core;
        timeout_err <= do_timeout;
        rr_last     <= bus_core;
      end
    end
  end

  // Watchdog counts cycles spent in WAIT_DONE, saturating, and clears on any exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if ((state == ST_WAIT_DONE) && !do_finish) begin
      wd_cnt <= (wd_cnt == CNT_MAX) ? wd_cnt : wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule
